// File: rtl/pw_entry_driver_if.sv
// ---------------------------------------------------------------------------
// pw_entry_driver_if
// Lock-side connection between pw_entry_driver (master) and the password
// lock pw_fsm (slave). It replaces the switches and the down button.
//   char_out   master->slave  character presented to the lock's char_in
//   enter_out  master->slave  enter strobe to the lock
//   open_in    slave->master  lock reports the guess was correct
//   wrong_in   slave->master  lock reports the guess was wrong
// ---------------------------------------------------------------------------
interface pw_entry_driver_if #(
  parameter int CHAR_W = 8
);
  logic [CHAR_W-1:0] char_out;
  logic              enter_out;
  logic              open_in;
  logic              wrong_in;

  modport master (
    output char_out,
    output enter_out,
    input  open_in,
    input  wrong_in
  );

  modport slave (
    input  char_out,
    input  enter_out,
    output open_in,
    output wrong_in
  );
endinterface

// File: rtl/pw_entry_driver.sv
// ---------------------------------------------------------------------------
// pw_entry_driver
// Automated initiator for the password lock. It replays a stored guess of
// PW_LEN characters onto the lock with cycle-exact timing, then reports
// whether the lock opened, reported wrong, or stayed silent (timeout).
//
// Ports
//   clk, reset_n   clock and asynchronous active-low reset (MMCM locked)
//   load_en/idx/char  write one guess slot; dropped while a run is active
//   start          begin a run; honoured only in IDLE or DONE
//   lock           pw_entry_driver_if.master: char_out, enter_out, open_in,
//                  wrong_in towards the lock
//   busy           run in progress (SETUP, PRESS or WAIT_RES)
//   done           run finished, result flags valid
//   res_open/res_wrong/res_timeout  latched outcome of the last run
//   trig           laser trigger
//
// Build option
//   PW_DRV_TRIG_EN  when defined, trig pulses for one cycle together with the
//                   rising edge of enter_out for the last character; when
//                   undefined, trig is tied low.
// ---------------------------------------------------------------------------
module pw_entry_driver #(
  parameter int PW_LEN   = 4,
  parameter int CHAR_W   = 8,
  parameter int HOLD_CYC = 4,
  parameter int GAP_CYC  = 8,
  parameter int TIMEOUT  = 255,
  localparam int IDX_W   = (PW_LEN > 1) ? $clog2(PW_LEN) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load_en,
  input  logic [IDX_W-1:0]    load_idx,
  input  logic [CHAR_W-1:0]   load_char,
  input  logic                start,
  pw_entry_driver_if.master   lock,
  output logic                busy,
  output logic                done,
  output logic                res_open,
  output logic                res_wrong,
  output logic                res_timeout,
  output logic                trig
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SETUP    = 3'd1;
  localparam logic [2:0] S_PRESS    = 3'd2;
  localparam logic [2:0] S_WAIT_RES = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  // One shared counter serves the gap, hold and timeout phases, so it is
  // sized for the largest of the three terminal counts.
  localparam int MAX_GH  = (GAP_CYC > HOLD_CYC) ? GAP_CYC : HOLD_CYC;
  localparam int MAX_ALL = (MAX_GH > TIMEOUT) ? MAX_GH : TIMEOUT;
  localparam int CNT_W   = $clog2(MAX_ALL + 1);

  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PW_LEN - 1);

  logic [2:0]        state;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  cnt;
  logic [CHAR_W-1:0] guess [PW_LEN];
  logic              idle_like;

  assign idle_like = (state == S_IDLE) || (state == S_DONE);
  assign busy      = (state == S_SETUP) || (state == S_PRESS) || (state == S_WAIT_RES);
  assign done      = (state == S_DONE);

  // Guess storage. Writes are only accepted between runs so the sequence
  // replayed is frozen from start to DONE.
  // NOTE: this small array is reset explicitly because a cleared guess is
  // observable behaviour; that forces flops rather than a RAM macro.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PW_LEN; i++) guess[i] <= '0;
    end else if (load_en && idle_like && (32'(load_idx) < PW_LEN)) begin
      guess[load_idx] <= load_char;
    end
  end

  // Sequencer. char_out and enter_out are registered and only move on state
  // transitions, so char_out never changes while enter_out is high.
  // NOTE: every state register here uses non-blocking assignment so all
  // updates see the pre-edge values of state, cnt and idx.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      idx            <= '0;
      cnt            <= '0;
      lock.char_out  <= '0;
      lock.enter_out <= 1'b0;
      res_open       <= 1'b0;
      res_wrong      <= 1'b0;
      res_timeout    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state         <= S_SETUP;
            idx           <= '0;
            cnt           <= '0;
            lock.char_out <= guess[0];
            res_open      <= 1'b0;
            res_wrong     <= 1'b0;
            res_timeout   <= 1'b0;
          end
        end
        S_SETUP: begin
          if (cnt == GAP_LAST) begin
            state          <= S_PRESS;
            cnt            <= '0;
            lock.enter_out <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_PRESS: begin
          if (cnt == HOLD_LAST) begin
            cnt            <= '0;
            lock.enter_out <= 1'b0;
            if (idx == LAST_IDX) begin
              state <= S_WAIT_RES;
            end else begin
              state         <= S_SETUP;
              idx           <= idx + 1'b1;
              lock.char_out <= guess[idx + 1'b1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_RES: begin
          // A lock response wins over a timeout landing in the same cycle.
          if (lock.open_in || lock.wrong_in) begin
            res_open      <= lock.open_in;
            res_wrong     <= lock.wrong_in;
            state         <= S_DONE;
            lock.char_out <= '0;
          end else if (cnt == TO_LAST) begin
            res_timeout   <= 1'b1;
            state         <= S_DONE;
            lock.char_out <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef PW_DRV_TRIG_EN
  // Fires on the same edge that raises enter_out for the last character.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trig <= 1'b0;
    end else begin
      trig <= (state == S_SETUP) && (cnt == GAP_LAST) && (idx == LAST_IDX);
    end
  end
`else
  assign trig = 1'b0;
`endif

endmodule

// File: tb/tb_pw_entry_driver.sv
module tb_pw_entry_driver;
  localparam int PW_LEN   = 4;
  localparam int CHAR_W   = 8;
  localparam int HOLD_CYC = 4;
  localparam int GAP_CYC  = 8;
  localparam int TIMEOUT  = 255;
  localparam int IDX_W    = 2;
  localparam int PERIOD   = GAP_CYC + HOLD_CYC;
  localparam int BUDGET   = PW_LEN * PERIOD + TIMEOUT + 40;
`ifdef PW_DRV_TRIG_EN
  localparam bit TRIG_EN = 1'b1;
`else
  localparam bit TRIG_EN = 1'b0;
`endif

  typedef struct { logic [CHAR_W-1:0] ch; int cyc; bit last; } press_t;
  typedef struct { bit o; bit w; bit t; int cyc; } res_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              load_en = 1'b0;
  logic [IDX_W-1:0]  load_idx = '0;
  logic [CHAR_W-1:0] load_char = '0;
  logic              start = 1'b0;
  logic              busy, done, res_open, res_wrong, res_timeout, trig;

  pw_entry_driver_if #(.CHAR_W(CHAR_W)) lk ();

  pw_entry_driver #(
    .PW_LEN(PW_LEN), .CHAR_W(CHAR_W), .HOLD_CYC(HOLD_CYC),
    .GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .load_en(load_en), .load_idx(load_idx),
    .load_char(load_char), .start(start), .lock(lk.master), .busy(busy),
    .done(done), .res_open(res_open), .res_wrong(res_wrong),
    .res_timeout(res_timeout), .trig(trig)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int n_res    = 0;

  press_t press_q[$];
  res_t   res_q[$];

  // Reference state: what the guess array should hold, and the lock's secret.
  logic [CHAR_W-1:0] model_guess [PW_LEN];
  logic [CHAR_W-1:0] lock_pw     [PW_LEN];
  int lock_mode  = 0;  // 0 judge guess, 1 never respond, 2 open+wrong together
  int lock_delay = 0;
  bit lock_noise = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
  endtask

  // Lock model: records characters at each enter rise and answers a
  // configurable number of cycles after the last enter release.
  initial begin : lock_model
    logic [CHAR_W-1:0] entered [$];
    int  presses;
    int  countdown;
    bit  prev_en;
    bit  match;
    presses = 0; countdown = -1; prev_en = 1'b0;
    lk.open_in = 1'b0; lk.wrong_in = 1'b0;
    forever begin
      @(negedge clk);
      lk.open_in  = 1'b0;
      lk.wrong_in = 1'b0;
      if (!reset_n || !busy) begin
        presses = 0; countdown = -1; entered.delete();
      end else begin
        if (lk.enter_out && !prev_en) entered.push_back(lk.char_out);
        if (!lk.enter_out && prev_en) begin
          presses++;
          if (lock_noise && presses == 2 && presses < PW_LEN) lk.wrong_in = 1'b1;
          if (presses == PW_LEN) countdown = lock_delay;
        end
        if (countdown == 0) begin
          countdown = -1;
          match = (entered.size() == PW_LEN);
          for (int i = 0; i < entered.size() && i < PW_LEN; i++)
            if (entered[i] !== lock_pw[i]) match = 1'b0;
          if (lock_mode == 0) begin
            lk.open_in = match; lk.wrong_in = !match;
          end else if (lock_mode == 2) begin
            lk.open_in = 1'b1; lk.wrong_in = 1'b1;
          end
        end else if (countdown > 0) begin
          countdown--;
        end
      end
      prev_en = lk.enter_out;
    end
  end

  // Monitor: pops expectations whenever the DUT presses enter or finishes.
  initial begin : monitor
    bit prev_en, prev_done;
    int rise_cyc;
    logic [CHAR_W-1:0] rise_ch;
    press_t p;
    res_t   r;
    prev_en = 1'b0; prev_done = 1'b0; rise_cyc = 0; rise_ch = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_en = 1'b0; prev_done = 1'b0;
        continue;
      end
      if (lk.enter_out && !prev_en) begin
        check("press_expected", press_q.size() != 0, 1'b1);
        if (press_q.size() != 0) begin
          p = press_q.pop_front();
          check("press_char", lk.char_out, p.ch);
          check("press_cyc", cyc, p.cyc);
          check("trig_at_press", trig, TRIG_EN && p.last);
        end
        rise_cyc = cyc;
        rise_ch  = lk.char_out;
      end else if (lk.enter_out && prev_en) begin
        check("char_stable_in_press", lk.char_out, rise_ch);
      end
      if (!lk.enter_out && prev_en) begin
        check("hold_width", cyc - rise_cyc, HOLD_CYC);
        check("trig_after_press", trig, 1'b0);
      end
      if (done && !prev_done) begin
        check("result_expected", res_q.size() != 0, 1'b1);
        if (res_q.size() != 0) begin
          r = res_q.pop_front();
          check("res_open", res_open, r.o);
          check("res_wrong", res_wrong, r.w);
          check("res_timeout", res_timeout, r.t);
          check("done_cyc", cyc, r.cyc);
          check("busy_at_done", busy, 1'b0);
          check("enter_idle_at_done", lk.enter_out, 1'b0);
          check("trig_at_done", trig, 1'b0);
        end
        n_res++;
      end
      prev_en   = lk.enter_out;
      prev_done = done;
    end
  end

  task automatic load(input int i, input logic [CHAR_W-1:0] ch);
    load_en = 1'b1; load_idx = IDX_W'(i); load_char = ch;
    @(negedge clk);
    load_en = 1'b0;
    if (i < PW_LEN) model_guess[i] = ch;
  endtask

  task automatic push_presses(input int c, input int count);
    for (int k = 0; k < count; k++)
      press_q.push_back('{model_guess[k], c + 1 + GAP_CYC + k * PERIOD, k == PW_LEN - 1});
  endtask

  // One complete run; poke adds ignored load/start traffic while busy.
  task automatic run(input int mode, input int delay, input bit noise, input bit poke);
    int c, f, n0, waited;
    bit match;
    res_t r;
    lock_mode = mode; lock_delay = delay; lock_noise = noise;
    c = cyc;
    f = c + 1 + PW_LEN * PERIOD;  // cycle the last enter release is seen
    match = 1'b1;
    for (int i = 0; i < PW_LEN; i++) if (model_guess[i] !== lock_pw[i]) match = 1'b0;
    push_presses(c, PW_LEN);
    case (mode)
      0:       r = '{match, !match, 1'b0, f + delay + 1};
      1:       r = '{1'b0, 1'b0, 1'b1, f + TIMEOUT};
      default: r = '{1'b1, 1'b1, 1'b0, f + delay + 1};
    endcase
    res_q.push_back(r);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n0 = n_res; waited = 0;
    while (n_res == n0 && waited < BUDGET) begin
      if (poke && waited == 5) begin
        load_en = 1'b1; load_idx = IDX_W'(PW_LEN - 1); load_char = ~model_guess[PW_LEN-1];
      end else if (poke && waited == 30) begin
        start = 1'b1;
      end else begin
        load_en = 1'b0; start = 1'b0;
      end
      @(negedge clk);
      waited++;
    end
    load_en = 1'b0; start = 1'b0;
    check("run_finished_in_budget", n_res != n0, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  initial begin : stimulus
    int c, r2;
    for (int i = 0; i < PW_LEN; i++) begin model_guess[i] = '0; lock_pw[i] = '0; end
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_char_out", lk.char_out, '0);
    check("rst_enter_out", lk.enter_out, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_res_flags", {res_open, res_wrong, res_timeout}, 3'b000);
    check("rst_trig", trig, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);

    // Correct guess ABCD -> open.
    load(0, "A"); load(1, "B"); load(2, "C"); load(3, "D");
    lock_pw = model_guess;
    run(0, 2, 1'b0, 1'b0);

    // ABCX with early wrong noise and ignored load/start while busy -> wrong.
    load(3, "X");
    run(0, 0, 1'b1, 1'b1);

    // Silent lock -> timeout exactly TIMEOUT cycles after the last release.
    run(1, 0, 1'b0, 1'b0);

    // open and wrong together -> both flags.
    run(2, 3, 1'b0, 1'b0);

    // Reset during the second press, then rerun from a cleared array.
    c = cyc;
    push_presses(c, 2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    r2 = c + 1 + GAP_CYC + PERIOD;
    while (cyc < r2 + 1) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("reset_mid_enter", lk.enter_out, 1'b0);
    check("reset_mid_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < PW_LEN; i++) model_guess[i] = '0;
    check("presses_before_reset", press_q.size(), 0);
    press_q.delete();
    @(negedge clk);
    for (int i = 0; i < PW_LEN; i++) lock_pw[i] = '0;
    run(0, 1, 1'b0, 1'b0);

    // Randomised runs.
    repeat (6) begin
      for (int i = 0; i < PW_LEN; i++) load(i, CHAR_W'($urandom));
      if ($urandom_range(0, 1) == 1) lock_pw = model_guess;
      else for (int i = 0; i < PW_LEN; i++) lock_pw[i] = CHAR_W'($urandom);
      run($urandom_range(0, 2), $urandom_range(0, 5), 1'(($urandom_range(0, 1))), 1'($urandom_range(0, 1)));
    end

    check("press_queue_drained", press_q.size(), 0);
    check("result_queue_drained", res_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
